adc_sar_ctrl: RTL

Digital successive-approximation controller for the 12-bit SAR ADC analog instrument. It accepts a conversion request, drives the sample, DAC-code and comparator-strobe signals, and resolves one bit per comparator decision from MSB to LSB. It returns the result over a start/done handshake. It sits between the JTAG-accessible register space of `dut` and the `ms_adc_*` mixed-signal boundary.

---
 rtl/adc_sar_pkg.sv | 26 ++
 rtl/adc_sar_ctrl_sar_reg.sv | 57 +++++
 rtl/adc_sar_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg
// Shared types and default constants for the 12-bit SAR ADC controller.
// Contents:
//   adc_sar_state_t      controller FSM states
//   ADC_SAR_N            default resolution in bits
//   ADC_SAR_SAMPLE_CYC   default sample-phase length in cycles
//   ADC_SAR_SETTLE_CYC   default DAC settling time before each strobe
//   ADC_SAR_TIMEOUT_CYC  default comparator wait limit (ADC_SAR_CTRL_TIMEOUT_EN builds)
`timescale 1ns/1ps
package adc_sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        STROBE,
        WAIT,
        DONE
    } adc_sar_state_t;

    localparam int ADC_SAR_N           = 12;
    localparam int ADC_SAR_SAMPLE_CYC  = 4;
    localparam int ADC_SAR_SETTLE_CYC  = 2;
    localparam int ADC_SAR_TIMEOUT_CYC = 16;

endpackage

// File: rtl/adc_sar_ctrl_sar_reg.sv
// sar_reg
// Trial-code register and bit index of the successive-approximation search.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      zero the trial code (sample phase drives a zero DAC code)
//   load_msb   trial = 1 << (N-1), index = N-1
//   resolve    keep or clear the current bit from cmp, then set the next
//              lower bit and step the index down (index 0 only resolves)
//   cmp        comparator decision, 1 keeps the current trial bit
//   trial      current trial code (drives the DAC directly)
//   index      position of the bit under test
//   resolved   trial code with the current bit already decided by cmp
`timescale 1ns/1ps
module sar_reg #(
    parameter int N = 12,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load_msb,
    input  logic          resolve,
    input  logic          cmp,
    output logic [N-1:0]  trial,
    output logic [IW-1:0] index,
    output logic [N-1:0]  resolved
);

    logic [N-1:0] bit_mask;

    // The decided code is exposed so the top can capture the final result
    // in the same edge that resolves the LSB.
    always_comb begin
        bit_mask = N'(1) << index;
        resolved = cmp ? trial : (trial & ~bit_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial <= '0;
            index <= '0;
        end else if (clear) begin
            trial <= '0;
        end else if (load_msb) begin
            trial <= N'(1) << (N - 1);
            index <= IW'(N - 1);
        end else if (resolve) begin
            if (index != '0) begin
                trial <= resolved | (bit_mask >> 1);
                index <= index - IW'(1);
            end else begin
                trial <= resolved;
            end
        end
    end

endmodule

// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl
// Successive-approximation controller for the 12-bit SAR ADC instrument.
// Samples the input, then resolves one bit per comparator decision from MSB
// to LSB and returns the code over a start/done handshake.
// Ports:
//   clk, rst    controller clock, asynchronous active-high reset
//   start       conversion request, sampled only in IDLE
//   busy        high from the cycle after an accepted start through DONE
//   done        one-cycle pulse, data/err valid in that cycle
//   data        last conversion result, held until the next done
//   err         comparator timeout flag, valid with done
//   ms_sample   sample switch enable
//   ms_dac      DAC trial code
//   ms_clk      comparator strobe
//   ms_rdy      comparator decision valid
//   ms_cmp      comparator result, 1 keeps the trial bit
// Configuration macro:
//   ADC_SAR_CTRL_TIMEOUT_EN  abort a conversion with err=1 when ms_rdy stays
//                            low for TIMEOUT_CYC consecutive WAIT cycles.
//                            Undefined: WAIT blocks and err is tied to 0.
// All outputs come straight from flops.
`timescale 1ns/1ps
module adc_sar_ctrl
    import adc_sar_pkg::*;
#(
    parameter int N           = ADC_SAR_N,
    parameter int SAMPLE_CYC  = ADC_SAR_SAMPLE_CYC,
    parameter int SETTLE_CYC  = ADC_SAR_SETTLE_CYC,
    parameter int TIMEOUT_CYC = ADC_SAR_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] data,
    output logic         err,
    output logic         ms_sample,
    output logic [N-1:0] ms_dac,
    output logic         ms_clk,
    input  logic         ms_rdy,
    input  logic         ms_cmp
);

    localparam int IW      = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC)
                           ? ((SAMPLE_CYC > TIMEOUT_CYC) ? SAMPLE_CYC : TIMEOUT_CYC)
                           : ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    adc_sar_state_t state, next_state;
    logic [CW-1:0]  cnt;
    logic           cnt_en;
    logic           sar_clear, sar_load, sar_resolve;
    logic [IW-1:0]  index;
    logic [N-1:0]   resolved;
`ifdef ADC_SAR_CTRL_TIMEOUT_EN
    logic           tmo_fire;
`endif

    // The trial register drives the DAC pins directly, so ms_dac is zeroed
    // on entry to SAMPLE and keeps the final code afterwards.
    sar_reg #(.N(N)) u_sar_reg (
        .clk      (clk),
        .rst      (rst),
        .clear    (sar_clear),
        .load_msb (sar_load),
        .resolve  (sar_resolve),
        .cmp      (ms_cmp),
        .trial    (ms_dac),
        .index    (index),
        .resolved (resolved)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and trial-register commands. The shared cycle counter
    // restarts on every state change, so within a state it holds the number
    // of cycles already spent there.
    always_comb begin
        next_state  = state;
        cnt_en      = 1'b0;
        sar_clear   = 1'b0;
        sar_load    = 1'b0;
        sar_resolve = 1'b0;
`ifdef ADC_SAR_CTRL_TIMEOUT_EN
        tmo_fire    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SAMPLE;
                    sar_clear  = 1'b1;
                end
            end
            SAMPLE: begin
                cnt_en = 1'b1;
                if (cnt == CW'(SAMPLE_CYC - 1)) begin
                    next_state = SETTLE;
                    sar_load   = 1'b1;
                end
            end
            SETTLE: begin
                cnt_en = 1'b1;
                if (cnt == CW'(SETTLE_CYC - 1)) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                next_state = WAIT;
            end
            WAIT: begin
`ifdef ADC_SAR_CTRL_TIMEOUT_EN
                cnt_en = 1'b1;
`endif
                if (ms_rdy) begin
                    sar_resolve = 1'b1;
                    next_state  = (index == '0) ? DONE : SETTLE;
                end
`ifdef ADC_SAR_CTRL_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    next_state = DONE;
                    tmo_fire   = 1'b1;
                end
`endif
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state || !cnt_en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Outputs are decoded from next_state and registered, so each output is
    // valid in the same cycle its state is current. The result is captured
    // on the edge that resolves the LSB, making data valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            ms_sample <= 1'b0;
            ms_clk    <= 1'b0;
            data      <= '0;
        end else begin
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
            ms_sample <= (next_state == SAMPLE);
            ms_clk    <= (next_state == STROBE);
            if (sar_resolve && index == '0) begin
                data <= resolved;
            end
        end
    end

`ifdef ADC_SAR_CTRL_TIMEOUT_EN
    // err is only ever set on the edge entering DONE, so it pulses with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= tmo_fire;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
